regfile_wr_arbiter: RTL and testbench

Shares the single register-file write port (write_addr/write_data/write_en) between NUM_REQ independent requesters (ALU writeback, load unit, host config) using a registered round-robin arbiter. Also sequences a full register-file clear sweep on command. Sits directly in front of the register file; read ports are untouched.

---
 rtl/regarb_pkg.sv | 19 +
 rtl/regfile_wr_arbiter_if.sv | 30 +++
 rtl/regarb_rr_picker.sv | 40 ++++
 rtl/regfile_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/regarb_pkg.sv
// Shared definitions for the register-file write arbiter: FSM state
// encoding, default widths matching the register file, clear-sweep depth.
package regarb_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_REQ    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Number of registers covered by a clear sweep.
    function automatic int reg_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester/write-port bundle between the requesters and the arbiter.
// Per-requester address and data are packed arrays, slice k = requester k.
interface regfile_wr_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 3
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_gnt;
    logic                               clear_req;
    logic [ADDR_WIDTH-1:0]              wr_addr;
    logic [DATA_WIDTH-1:0]              wr_data;
    logic                               wr_en;
    logic                               busy;
    logic                               clear_done;

    // Requester side
    modport master (
        output req_valid, req_addr, req_data, clear_req,
        input  req_gnt, wr_addr, wr_data, wr_en, busy, clear_done
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_data, clear_req,
        output req_gnt, wr_addr, wr_data, wr_en, busy, clear_done
    );
endinterface

// File: rtl/regarb_rr_picker.sv
// Combinational winner select over an eligible mask.
// Default: round-robin starting at rr_ptr.
// REGARB_FIXED_PRIO_EN: lowest eligible index wins, no pointer input.
module regarb_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
`ifndef REGARB_FIXED_PRIO_EN
    input  logic [PTR_W-1:0]   rr_ptr,
`endif
    output logic [NUM_REQ-1:0] win_onehot,
    output logic               found,
    output logic [PTR_W-1:0]   win_idx
);

    // Scan from the highest search offset down so the last hit is the
    // closest eligible index to the search start.
    always_comb begin
        int j;
        j       = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
`ifdef REGARB_FIXED_PRIO_EN
            j = i;
`else
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ)
                j = j - NUM_REQ;
`endif
            if (eligible[PTR_W'(j)]) begin
                found   = 1'b1;
                win_idx = PTR_W'(j);
            end
        end
        win_onehot = found ? (NUM_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: registered round-robin grant among
// NUM_REQ requesters plus a full-depth clear sweep on clear_req.
// Optional macro REGARB_FIXED_PRIO_EN selects fixed (lowest index) priority.
module regfile_wr_arbiter
    import regarb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  bus
);

    localparam int PTR_W     = $clog2(NUM_REQ);
    localparam int REG_DEPTH = reg_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_DEPTH - 1);

    state_e                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]   cnt_inc;

    logic                    wr_en_q, wr_en_nxt;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_nxt;
    logic [NUM_REQ-1:0]      gnt_q, gnt_nxt;
    logic                    busy_q, busy_nxt;
    logic                    done_q, done_nxt;

    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      win_onehot;
    logic                    found;
    logic [PTR_W-1:0]        win_idx;

`ifndef REGARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
`endif

    // A requester granted last cycle is still showing its old request.
    assign eligible = bus.req_valid & ~gnt_q;
    assign cnt_inc  = cnt + ADDR_WIDTH'(1);

    regarb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .eligible   (eligible),
`ifndef REGARB_FIXED_PRIO_EN
        .rr_ptr     (rr_ptr),
`endif
        .win_onehot (win_onehot),
        .found      (found),
        .win_idx    (win_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: leave CLEAR when the last address is being loaded so the
    // final sweep cycle is already IDLE and can arbitrate for the next one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.clear_req) state_nxt = CLEAR;
            CLEAR:   if (cnt_inc == LAST_ADDR) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered write port, grant and sweep flags
    always_comb begin
        cnt_nxt     = cnt;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr_q;
        wr_data_nxt = wr_data_q;
        gnt_nxt     = '0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
        rr_ptr_nxt  = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    cnt_nxt     = '0;
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = '0;
                    wr_data_nxt = '0;
                    busy_nxt    = 1'b1;
                    done_nxt    = (LAST_ADDR == '0);
                end else if (found) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = bus.req_addr[win_idx];
                    wr_data_nxt = bus.req_data[win_idx];
                    gnt_nxt     = win_onehot;
`ifndef REGARB_FIXED_PRIO_EN
                    rr_ptr_nxt  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
`endif
                end
            end
            CLEAR: begin
                cnt_nxt     = cnt_inc;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = cnt_inc;
                wr_data_nxt = '0;
                busy_nxt    = 1'b1;
                done_nxt    = (cnt_inc == LAST_ADDR);
            end
            default: ;
        endcase
    end

    // Output and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            cnt       <= cnt_nxt;
            wr_en_q   <= wr_en_nxt;
            wr_addr_q <= wr_addr_nxt;
            wr_data_q <= wr_data_nxt;
            gnt_q     <= gnt_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
`ifndef REGARB_FIXED_PRIO_EN
            rr_ptr    <= rr_ptr_nxt;
`endif
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.req_gnt    = gnt_q;
    assign bus.busy       = busy_q;
    assign bus.clear_done = done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, single grant, three-way
// arbitration, clear sweep with pending request, reset mid-sweep, and
// two-requester alternation with a late third requester.
module tb_regfile_wr_arbiter;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

    regfile_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.clear_req = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.wr_en, bus.busy, bus.clear_done, bus.req_gnt, bus.wr_addr, bus.wr_data});
    endfunction

    initial begin
        logic [2:0]  gnt_tab  [6];
        logic [15:0] data_tab [6];
        logic        done_seen;
        int          done_cyc;

        // 1. reset held two cycles, then idle outputs stay zero
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("reset_idle", outs(), 32'h0);
            tick();
        end

        // 2. single request from requester 1
        bus.req_valid   = 3'b010;
        bus.req_addr[1] = 5'd5;
        bus.req_data[1] = 16'hBEEF;
        tick();
        chk("single_en",   32'(bus.wr_en),   32'h1);
        chk("single_addr", 32'(bus.wr_addr), 32'h5);
        chk("single_data", 32'(bus.wr_data), 32'hBEEF);
        chk("single_gnt",  32'(bus.req_gnt), 32'h2);
        bus.req_valid = '0;
        tick();
        chk("single_drop_en",  32'(bus.wr_en),   32'h0);
        chk("single_drop_gnt", 32'(bus.req_gnt), 32'h0);

        // 3. all three requesters continuously valid
        do_reset();
`ifdef REGARB_FIXED_PRIO_EN
        gnt_tab  = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
        data_tab = '{16'd1, 16'd2, 16'd1, 16'd2, 16'd1, 16'd2};
`else
        gnt_tab  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        data_tab = '{16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3};
`endif
        for (int k = 0; k < NR; k++) begin
            bus.req_addr[k] = AW'(10 + k);
            bus.req_data[k] = DW'(k + 1);
        end
        bus.req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_gnt",  32'(bus.req_gnt), 32'(gnt_tab[i]));
            chk("rr_data", 32'(bus.wr_data), 32'(data_tab[i]));
        end
        bus.req_valid = '0;
        tick();
        chk("rr_idle_en", 32'(bus.wr_en), 32'h0);

        // 4. clear sweep wins over a simultaneous request, with a stray
        //    clear_req mid-sweep that must be ignored
        do_reset();
        bus.clear_req   = 1'b1;
        bus.req_valid   = 3'b100;
        bus.req_addr[2] = 5'd7;
        bus.req_data[2] = 16'h55AA;
        tick();
        bus.clear_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("clr_sweep", outs(),
                32'({1'b1, 1'b1, (i == 31), 3'b000, 5'(i), 16'h0000}));
            bus.clear_req = (i == 5);
            tick();
        end
        bus.clear_req = 1'b0;
        chk("clr_post_gnt",  32'(bus.req_gnt),    32'h4);
        chk("clr_post_addr", 32'(bus.wr_addr),    32'h7);
        chk("clr_post_data", 32'(bus.wr_data),    32'h55AA);
        chk("clr_post_busy", 32'(bus.busy),       32'h0);
        chk("clr_post_done", 32'(bus.clear_done), 32'h0);
        bus.req_valid = '0;
        tick();
        chk("clr_idle_en", 32'(bus.wr_en), 32'h0);

        // 5. reset during the 10th sweep cycle aborts without clear_done
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("abort_addr9", 32'({bus.wr_en, bus.busy, bus.wr_addr}), 32'({1'b1, 1'b1, 5'd9}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_outs", outs(), 32'h0);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.clear_done || bus.busy) done_seen = 1'b1;
            tick();
        end
        chk("abort_no_done", 32'(done_seen), 32'h0);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        chk("restart_first", 32'({bus.wr_en, bus.busy, bus.wr_addr}), 32'({1'b1, 1'b1, 5'd0}));
        done_cyc = -1;
        for (int i = 1; i < 40 && done_cyc < 0; i++) begin
            tick();
            if (bus.clear_done) done_cyc = i;
        end
        chk("restart_done_cyc", 32'(done_cyc), 32'd31);
        chk("restart_done_addr", 32'(bus.wr_addr), 32'd31);
        tick();
        chk("restart_busy_off", 32'(bus.busy), 32'h0);

        // 6. requesters 0 and 2 alternate; requester 1 arrives late and is
        //    served right after the next grant to requester 0
        do_reset();
        bus.req_addr[0] = 5'd1;  bus.req_data[0] = 16'h00A0;
        bus.req_addr[1] = 5'd2;  bus.req_data[1] = 16'h00A1;
        bus.req_addr[2] = 5'd3;  bus.req_data[2] = 16'h00A2;
        bus.req_valid   = 3'b101;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_gnt", 32'(bus.req_gnt), (i % 2 == 0) ? 32'h1 : 32'h4);
        end
        bus.req_valid = 3'b111;
        tick();
        chk("late_gnt0", 32'(bus.req_gnt), 32'h1);
        tick();
        chk("late_gnt1",  32'(bus.req_gnt), 32'h2);
        chk("late_data1", 32'(bus.wr_data), 32'h00A1);
        bus.req_valid = '0;
        tick();
        chk("late_idle_en", 32'(bus.wr_en), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
